// File: rtl/cpu_controller.sv
// Eight-state instruction sequencer for the 8-bit accumulator CPU.
// Define CTRL_ICOUNT_EN to add the retired-instruction counter output.
module cpu_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [2:0]           opcode,
    input  logic                 zero,
    output logic [2:0]           state,
    output logic                 halt,
    output logic                 load_ir,
    output logic                 inc_pc,
    output logic                 load_pc,
    output logic                 rd,
    output logic                 wr,
    output logic                 datactl_ena,
    output logic                 alu_ena,
    output logic                 load_acc
`ifdef CTRL_ICOUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] instr_count
`endif
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic       halted;
    logic       halted_next;
    logic [2:0] state_next;
    logic       active;
    logic       alu_op;

    // Any cycle that may advance or emit strobes.
    assign active = run & ~halted & ~rst;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= 3'd7;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    always_comb begin
        state_next  = state;
        halted_next = halted;
        if (active) begin
            if (state == 3'd3 && opcode == OP_HLT) begin
                halted_next = 1'b1;
            end else begin
                state_next = state + 3'd1;
            end
        end
    end

    always_comb begin
        halt        = halted & ~rst;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        datactl_ena = 1'b0;
        alu_ena     = 1'b0;
        load_acc    = 1'b0;
        if (active) begin
            unique case (state)
                3'd0, 3'd1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                3'd4: begin
                    if (alu_op) begin
                        rd      = 1'b1;
                        alu_ena = 1'b1;
                    end else if (opcode == OP_SKZ || opcode == OP_STO) begin
                        alu_ena = 1'b1;
                    end else if (opcode == OP_JMP) begin
                        load_pc = 1'b1;
                    end
                end
                3'd5: begin
                    if (alu_op) begin
                        rd       = 1'b1;
                        load_acc = 1'b1;
                    end else if (opcode == OP_STO) begin
                        datactl_ena = 1'b1;
                        wr          = 1'b1;
                    end else if (opcode == OP_SKZ) begin
                        inc_pc = zero;
                    end else if (opcode == OP_JMP) begin
                        load_pc = 1'b1;
                    end
                end
                3'd6: begin
                    if (alu_op) begin
                        rd = 1'b1;
                    end else if (opcode == OP_STO) begin
                        datactl_ena = 1'b1;
                    end else if (opcode == OP_SKZ) begin
                        inc_pc = zero;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_ICOUNT_EN
    // Retire on S6->S7; HLT never gets past S3 so is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
        end else if (active && state == 3'd6) begin
            instr_count <= instr_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller.
// Strobe vector: {halt,load_ir,inc_pc,load_pc,rd,wr,datactl_ena,alu_ena,load_acc}.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       halt, load_ir, inc_pc, load_pc, rd, wr;
    logic       datactl_ena, alu_ena, load_acc;
`ifdef CTRL_ICOUNT_EN
    logic [3:0] instr_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [8:0] strobes;
    assign strobes = {halt, load_ir, inc_pc, load_pc, rd, wr,
                      datactl_ena, alu_ena, load_acc};

    cpu_controller #(.CNT_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .state       (state),
        .halt        (halt),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .datactl_ena (datactl_ena),
        .alu_ena     (alu_ena),
        .load_acc    (load_acc)
`ifdef CTRL_ICOUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [8:0] FETCH = 9'h0D0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction from S7 back to S7, checked against a hand table.
    task automatic run_instr(input string name, input logic [8:0] tbl [8]);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (state !== 3'(i)) begin
                errors++;
                $display("FAIL %s state: got %0d want %0d", name, state, i);
            end
            checks++;
            if (strobes !== tbl[i]) begin
                errors++;
                $display("FAIL %s strobes S%0d: got %h want %h",
                         name, i, strobes, tbl[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; opcode = 3'd2; zero = 1'b0;
        step();
        step();
        checks++;
        if (state !== 3'd7 || strobes !== 9'h000) begin
            errors++;
            $display("FAIL reset: got state=%0d strobes=%h want 7/000",
                     state, strobes);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [8:0] t [8];
        t = '{9'h000, FETCH, FETCH, 9'h000, 9'h000,
              9'h012, 9'h011, 9'h010};
        // table index i maps to state i; element 0 is S0
        t = '{FETCH, FETCH, 9'h000, 9'h000, 9'h012,
              9'h011, 9'h010, 9'h000};
        opcode = 3'd2; zero = 1'b0;
        run_instr("add", t);
        run_instr("add_b2b", t);
    endtask

    task automatic test_skz();
        logic [8:0] t1 [8];
        logic [8:0] t0 [8];
        t1 = '{FETCH, FETCH, 9'h000, 9'h000, 9'h002,
               9'h040, 9'h040, 9'h000};
        t0 = '{FETCH, FETCH, 9'h000, 9'h000, 9'h002,
               9'h000, 9'h000, 9'h000};
        opcode = 3'd1; zero = 1'b1;
        run_instr("skz_z1", t1);
        zero = 1'b0;
        run_instr("skz_z0", t0);
    endtask

    task automatic test_sto();
        logic [8:0] t [8];
        t = '{FETCH, FETCH, 9'h000, 9'h000, 9'h002,
              9'h00C, 9'h004, 9'h000};
        opcode = 3'd6; zero = 1'b0;
        run_instr("sto", t);
    endtask

    task automatic test_jmp();
        logic [8:0] t [8];
        t = '{FETCH, FETCH, 9'h000, 9'h000, 9'h020,
              9'h020, 9'h000, 9'h000};
        opcode = 3'd7; zero = 1'b1;
        run_instr("jmp", t);
    endtask

    task automatic test_run_pause();
        opcode = 3'd2; zero = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (state !== 3'd4 || strobes !== 9'h012) begin
            errors++;
            $display("FAIL pause_s4: got %0d/%h want 4/012", state, strobes);
        end
        run = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== 3'd4 || strobes !== 9'h000) begin
                errors++;
                $display("FAIL pause_hold: got %0d/%h want 4/000",
                         state, strobes);
            end
            step();
        end
        run = 1'b1;
        #1;
        checks++;
        if (state !== 3'd4 || strobes !== 9'h012) begin
            errors++;
            $display("FAIL pause_resume: got %0d/%h want 4/012",
                     state, strobes);
        end
        step();
        checks++;
        if (state !== 3'd5 || strobes !== 9'h011) begin
            errors++;
            $display("FAIL pause_s5: got %0d/%h want 5/011", state, strobes);
        end
        step();
        step();
    endtask

    task automatic test_rst_mid();
        opcode = 3'd6;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        #1;
        checks++;
        if (strobes !== 9'h000) begin
            errors++;
            $display("FAIL rst_mid_strobes: got %h want 000", strobes);
        end
        step();
        checks++;
        if (state !== 3'd7 || strobes !== 9'h000) begin
            errors++;
            $display("FAIL rst_mid: got %0d/%h want 7/000", state, strobes);
        end
        rst = 1'b0;
    endtask

    task automatic test_hlt();
        opcode = 3'd0; zero = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (state !== 3'd3 || strobes !== 9'h000) begin
            errors++;
            $display("FAIL hlt_s3: got %0d/%h want 3/000", state, strobes);
        end
        for (int i = 0; i < 22; i++) begin
            if (i == 10) run = 1'b0;
            if (i == 12) run = 1'b1;
            step();
            checks++;
            if (state !== 3'd3 || strobes !== 9'h100) begin
                errors++;
                $display("FAIL hlt_hold: got %0d/%h want 3/100",
                         state, strobes);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 3'd7 || halt !== 1'b0) begin
            errors++;
            $display("FAIL hlt_exit: got state=%0d halt=%b want 7/0",
                     state, halt);
        end
    endtask

`ifdef CTRL_ICOUNT_EN
    task automatic test_icount();
        checks++;
        if (instr_count !== 4'd0) begin
            errors++;
            $display("FAIL icount_rst: got %0d want 0", instr_count);
        end
        opcode = 3'd5;
        for (int i = 0; i < 16 * 8; i++) step();
        checks++;
        if (instr_count !== 4'd0) begin
            errors++;
            $display("FAIL icount_wrap: got %0d want 0", instr_count);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (instr_count !== 4'd1) begin
            errors++;
            $display("FAIL icount_17: got %0d want 1", instr_count);
        end
        opcode = 3'd0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (instr_count !== 4'd1 || halt !== 1'b1) begin
            errors++;
            $display("FAIL icount_hlt: got %0d/%b want 1/1",
                     instr_count, halt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (instr_count !== 4'd0) begin
            errors++;
            $display("FAIL icount_clr: got %0d want 0", instr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_skz();
        test_sto();
        test_jmp();
        test_run_pause();
        test_rst_mid();
        test_hlt();
`ifdef CTRL_ICOUNT_EN
        test_icount();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
